// File: rtl/ring_mem_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : ring_mem_requester_if
// Brief    : Ring slot, read-return and core request bundle for the requester.
// Revision : 1.0
// ============================================================================
interface ring_mem_requester_if;
    logic [31:0] RingIn;
    logic [3:0]  SlotTypeIn;
    logic [3:0]  SrcDestIn;
    logic [31:0] RingOut;
    logic [3:0]  SlotTypeOut;
    logic [3:0]  SrcDestOut;
    logic [31:0] RDreturn;
    logic [3:0]  RDdest;
    logic        reqValid;
    logic        reqReady;
    logic        reqRead;
    logic        reqInstr;
    logic [25:0] reqAddr;
    logic [2:0]  wrIndex;
    logic [31:0] wrWord;
    logic        rdValid;
    logic [2:0]  rdIndex;
    logic [31:0] rdWord;
    logic        done;
    logic        protoErr;

    // Node side
    modport slave (
        input  RingIn, SlotTypeIn, SrcDestIn, RDreturn, RDdest,
        input  reqValid, reqRead, reqInstr, reqAddr, wrWord,
        output RingOut, SlotTypeOut, SrcDestOut, reqReady, wrIndex,
        output rdValid, rdIndex, rdWord, done, protoErr
    );

    // Core / ring environment side
    modport master (
        output RingIn, SlotTypeIn, SrcDestIn, RDreturn, RDdest,
        output reqValid, reqRead, reqInstr, reqAddr, wrWord,
        input  RingOut, SlotTypeOut, SrcDestOut, reqReady, wrIndex,
        input  rdValid, rdIndex, rdWord, done, protoErr
    );
endinterface
`default_nettype wire

// File: rtl/ring_mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : ring_mem_requester
// Brief    : DDR ring node; joins the Token train with Address/WriteData slots.
// Revision : 1.0
// ============================================================================
module ring_mem_requester #(
    parameter logic [3:0] CORE_ID = 4'd1
) (
    input  wire logic             clock,
    input  wire logic             resetB,
    ring_mem_requester_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_FWD   = 3'd2,
        S_INJ   = 3'd3,
        S_WRD   = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [25:0] r_addr, w_addr_nxt;
    logic        r_read, w_read_nxt;
    logic        r_instr, w_instr_nxt;
    logic [3:0]  r_n, w_n_nxt;
    logic [7:0]  r_fwd_cnt, w_fwd_nxt;
    logic [3:0]  r_inj_cnt, w_inj_nxt;
    logic [2:0]  r_rd_cnt, w_rd_cnt_nxt;
    logic        r_hold_vld, w_hold_vld_nxt;
    logic [31:0] r_hold_data, w_hold_data_nxt;
    logic [3:0]  r_hold_type, w_hold_type_nxt;
    logic [3:0]  r_hold_sd, w_hold_sd_nxt;
    logic [31:0] r_ring_out, w_ring_nxt;
    logic [3:0]  r_type_out, w_type_nxt;
    logic [3:0]  r_sd_out, w_sd_nxt;
    logic        r_rd_valid, w_rd_valid_nxt;
    logic [2:0]  r_rd_index, w_rd_index_nxt;
    logic [31:0] r_rd_word, w_rd_word_nxt;
    logic        r_done, w_done_nxt;
    logic        r_proto_err, w_err_nxt;

    logic        w_in_empty, w_in_msg, w_in_token, w_rd_hit;
    logic [8:0]  w_sum;
    logic [3:0]  w_inj_m1;

    assign w_in_empty = (bus.SlotTypeIn == 4'd0) || (bus.SlotTypeIn == 4'd7);
    assign w_in_msg   = bus.SlotTypeIn[3];
    assign w_in_token = (bus.SlotTypeIn == 4'd1);
    assign w_rd_hit   = (bus.RDdest == CORE_ID);
    assign w_sum      = {1'b0, bus.RingIn[7:0]} + {5'b0, r_n};
    assign w_inj_m1   = r_inj_cnt - 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_read_nxt      = r_read;
        w_instr_nxt     = r_instr;
        w_n_nxt         = r_n;
        w_fwd_nxt       = r_fwd_cnt;
        w_inj_nxt       = r_inj_cnt;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_hold_vld_nxt  = r_hold_vld;
        w_hold_data_nxt = r_hold_data;
        w_hold_type_nxt = r_hold_type;
        w_hold_sd_nxt   = r_hold_sd;
        w_ring_nxt      = bus.RingIn;
        w_type_nxt      = bus.SlotTypeIn;
        w_sd_nxt        = bus.SrcDestIn;
        w_rd_valid_nxt  = 1'b0;
        w_rd_index_nxt  = r_rd_index;
        w_rd_word_nxt   = r_rd_word;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_proto_err;

        // A held Message goes out on the first cycle the downstream slot is free
        if (r_hold_vld && w_in_empty && (r_state != S_INJ)) begin
            w_ring_nxt     = r_hold_data;
            w_type_nxt     = r_hold_type;
            w_sd_nxt       = r_hold_sd;
            w_hold_vld_nxt = 1'b0;
        end

        if (w_rd_hit && (r_state != S_WRD)) begin
            w_err_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.reqValid) begin
                    w_addr_nxt  = bus.reqAddr;
                    w_read_nxt  = bus.reqRead;
                    w_instr_nxt = bus.reqInstr;
                    w_n_nxt     = bus.reqRead ? 4'd1 : 4'd9;
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // Joining is deferred while the 8-bit slot count would overflow
                if (w_in_token && !w_sum[8]) begin
                    w_ring_nxt  = {bus.RingIn[31:8], w_sum[7:0]};
                    w_fwd_nxt   = bus.RingIn[7:0];
                    w_inj_nxt   = 4'd0;
                    w_state_nxt = (bus.RingIn[7:0] != 8'd0) ? S_FWD : S_INJ;
                end
            end
            S_FWD: begin
                w_fwd_nxt = r_fwd_cnt - 8'd1;
                if (r_fwd_cnt == 8'd1) begin
                    w_state_nxt = S_INJ;
                end
            end
            S_INJ: begin
                w_sd_nxt = CORE_ID;
                if (!w_in_empty) begin
                    if (w_in_msg && !r_hold_vld) begin
                        w_hold_vld_nxt  = 1'b1;
                        w_hold_data_nxt = bus.RingIn;
                        w_hold_type_nxt = bus.SlotTypeIn;
                        w_hold_sd_nxt   = bus.SrcDestIn;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                if (r_inj_cnt == 4'd0) begin
                    w_type_nxt = 4'd2;
                    w_ring_nxt = {2'b00, r_instr, r_read, 2'b00, r_addr};
                    if (r_read) begin
                        w_state_nxt = S_WRD;
                    end else begin
                        w_inj_nxt = 4'd1;
                    end
                end else begin
                    w_type_nxt = 4'd3;
                    w_ring_nxt = bus.wrWord;
                    if (r_inj_cnt == 4'd8) begin
                        w_inj_nxt   = 4'd0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_inj_nxt = r_inj_cnt + 4'd1;
                    end
                end
            end
            S_WRD: begin
                if (w_rd_hit) begin
                    w_rd_valid_nxt = 1'b1;
                    w_rd_index_nxt = r_rd_cnt;
                    w_rd_word_nxt  = bus.RDreturn;
                    w_rd_cnt_nxt   = r_rd_cnt + 3'd1;
                    if (r_rd_cnt == 3'd7) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetB) begin
        if (!resetB) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_read      <= 1'b0;
            r_instr     <= 1'b0;
            r_n         <= '0;
            r_fwd_cnt   <= '0;
            r_inj_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_hold_type <= '0;
            r_hold_sd   <= '0;
            r_ring_out  <= '0;
            r_type_out  <= '0;
            r_sd_out    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_index  <= '0;
            r_rd_word   <= '0;
            r_done      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_read      <= w_read_nxt;
            r_instr     <= w_instr_nxt;
            r_n         <= w_n_nxt;
            r_fwd_cnt   <= w_fwd_nxt;
            r_inj_cnt   <= w_inj_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_hold_vld  <= w_hold_vld_nxt;
            r_hold_data <= w_hold_data_nxt;
            r_hold_type <= w_hold_type_nxt;
            r_hold_sd   <= w_hold_sd_nxt;
            r_ring_out  <= w_ring_nxt;
            r_type_out  <= w_type_nxt;
            r_sd_out    <= w_sd_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_index  <= w_rd_index_nxt;
            r_rd_word   <= w_rd_word_nxt;
            r_done      <= w_done_nxt;
            r_proto_err <= w_err_nxt;
        end
    end

    assign bus.RingOut     = r_ring_out;
    assign bus.SlotTypeOut = r_type_out;
    assign bus.SrcDestOut  = r_sd_out;
    assign bus.reqReady    = (r_state == S_IDLE);
    assign bus.wrIndex     = ((r_state == S_INJ) && (r_inj_cnt != 4'd0)) ? w_inj_m1[2:0] : 3'd0;
    assign bus.rdValid     = r_rd_valid;
    assign bus.rdIndex     = r_rd_index;
    assign bus.rdWord      = r_rd_word;
    assign bus.done        = r_done;
    assign bus.protoErr    = r_proto_err;
endmodule
`default_nettype wire

// File: tb/tb_ring_mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_mem_requester
// Brief    : Self-checking bench for ring_mem_requester against a slot-stream model.
// Revision : 1.0
// ============================================================================
module tb_ring_mem_requester;
    localparam logic [3:0] ID = 4'd1;

    logic clock = 1'b0;
    logic resetB = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] wr_data [8];

    ring_mem_requester_if bus ();

    ring_mem_requester #(.CORE_ID(ID)) dut (
        .clock  (clock),
        .resetB (resetB),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    assign bus.wrWord = wr_data[bus.wrIndex];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_slot(input logic [3:0] t, input logic [3:0] sd, input logic [31:0] d);
        bus.SlotTypeIn = t;
        bus.SrcDestIn  = sd;
        bus.RingIn     = d;
    endtask

    function automatic logic [39:0] out_slot();
        return {bus.RingOut, bus.SlotTypeOut, bus.SrcDestOut};
    endfunction

    task automatic request(input bit rd, input bit ins, input logic [25:0] a);
        for (int i = 0; i < 8; i++) wr_data[i] = $urandom;
        drive_slot(4'd0, 4'd0, 32'd0);
        check("ready_idle", bus.reqReady, 1);
        bus.reqValid = 1'b1;
        bus.reqRead  = rd;
        bus.reqInstr = ins;
        bus.reqAddr  = a;
        tick();
        bus.reqValid = 1'b0;
        bus.reqRead  = ~rd;
        bus.reqAddr  = 26'($urandom);
        check("ready_armed", bus.reqReady, 0);
    endtask

    // Token with slot count cnt; accept says whether the node is expected to join
    task automatic send_token(input int cnt, input int n, input bit accept);
        logic [31:0] r;
        logic [31:0] tok;
        r   = $urandom;
        tok = {r[31:8], 8'(cnt)};
        drive_slot(4'd1, r[3:0], tok);
        tick();
        if (accept)
            check("token_join", out_slot(), {r[31:8], 8'(cnt + n), 4'd1, r[3:0]});
        else begin
            check("token_defer", out_slot(), {tok, 4'd1, r[3:0]});
            check("ready_defer", bus.reqReady, 0);
        end
    endtask

    task automatic finish_txn(input bit rd, input bit ins, input logic [25:0] a, input int cnt,
                              input int fixed_gap, input int msg_slot, input int stop_after);
        logic [31:0] r;
        logic [3:0]  t;
        logic [31:0] exp_addr;
        logic [39:0] msg;
        exp_addr = (32'(ins) << 29) | (32'(rd) << 28) | 32'(a);
        msg = '0;
        for (int i = 0; i < cnt; i++) begin
            r = $urandom;
            t = r[0] ? 4'(2 + r[1]) : {1'b1, r[3:1]};
            drive_slot(t, r[7:4], r);
            tick();
            check("fwd_slot", out_slot(), {r, t, r[7:4]});
        end
        r = $urandom;
        drive_slot(r[0] ? 4'd0 : 4'd7, r[7:4], r);
        tick();
        check("addr_slot", out_slot(), {exp_addr, 4'd2, ID});
        if (!rd) begin
            for (int i = 0; i < 8; i++) begin
                check("wr_index", bus.wrIndex, 64'(i));
                r = $urandom;
                if (i == msg_slot) begin
                    msg = {r, 4'd8 + 4'(r[2:0]), r[11:8]};
                    drive_slot(msg[7:4], msg[3:0], msg[39:8]);
                end else
                    drive_slot(r[0] ? 4'd0 : 4'd7, r[7:4], r);
                tick();
                check("wr_slot", out_slot(), {wr_data[i], 4'd3, ID});
                check("wr_done", bus.done, (i == 7) ? 1 : 0);
            end
            check("ready_after_wr", bus.reqReady, 1);
            drive_slot(4'd0, 4'd0, 32'd0);
            tick();
            if (msg_slot >= 0) check("msg_fwd", out_slot(), msg);
            check("done_once_wr", bus.done, 0);
        end else begin
            drive_slot(4'd0, 4'd0, 32'd0);
            for (int k = 0; k < stop_after; k++) begin
                int g;
                g = (fixed_gap >= 0) ? ((k == 4) ? fixed_gap : 0) : int'($urandom_range(0, 2));
                repeat (g) begin
                    bus.RDdest   = r[0] ? 4'd0 : ID + 4'd1;
                    bus.RDreturn = $urandom;
                    tick();
                    check("rd_gap", bus.rdValid, 0);
                end
                r = $urandom;
                bus.RDdest   = ID;
                bus.RDreturn = r;
                tick();
                bus.RDdest = 4'd0;
                check("rd_valid", bus.rdValid, 1);
                check("rd_index", bus.rdIndex, 64'(k));
                check("rd_word", bus.rdWord, r);
                check("rd_done", bus.done, (k == 7) ? 1 : 0);
            end
            if (stop_after == 8) begin
                tick();
                check("done_once_rd", bus.done, 0);
                check("rd_valid_end", bus.rdValid, 0);
                check("ready_after_rd", bus.reqReady, 1);
            end
        end
    endtask

    initial begin
        logic [25:0] a;
        bit          rd;
        int          cnt;
        bus.RingIn = '0; bus.SlotTypeIn = '0; bus.SrcDestIn = '0;
        bus.RDreturn = '0; bus.RDdest = '0;
        bus.reqValid = 1'b0; bus.reqRead = 1'b0; bus.reqInstr = 1'b0; bus.reqAddr = '0;
        for (int i = 0; i < 8; i++) wr_data[i] = '0;
        #12;
        check("rst_slot", out_slot(), 40'd0);
        check("rst_ready", bus.reqReady, 1);
        check("rst_misc", {bus.rdValid, bus.rdIndex, bus.rdWord, bus.done, bus.protoErr, bus.wrIndex}, 0);
        resetB = 1'b1;

        // Read at the head of an empty train
        request(1'b1, 1'b0, 26'h0ABCDE);
        send_token(0, 1, 1'b1);
        finish_txn(1'b1, 1'b0, 26'h0ABCDE, 0, -1, -1, 8);

        // Write behind three existing slots, known data pattern
        a = 26'($urandom);
        request(1'b0, 1'b0, a);
        for (int i = 0; i < 8; i++) wr_data[i] = 32'hA0 + 32'(i);
        send_token(3, 9, 1'b1);
        finish_txn(1'b0, 1'b0, a, 3, -1, -1, 8);

        // Overflow deferral for writes and reads at the 255 boundary
        a = 26'($urandom);
        request(1'b0, 1'b1, a);
        send_token(250, 9, 1'b0);
        send_token(0, 9, 1'b1);
        finish_txn(1'b0, 1'b1, a, 0, -1, -1, 8);
        a = 26'($urandom);
        request(1'b1, 1'b1, a);
        send_token(255, 1, 1'b0);
        send_token(254, 1, 1'b1);
        finish_txn(1'b1, 1'b1, a, 254, -1, -1, 8);

        // Read with a two-cycle gap before word 4
        a = 26'($urandom);
        request(1'b1, 1'b0, a);
        send_token(2, 1, 1'b1);
        finish_txn(1'b1, 1'b0, a, 2, 2, -1, 8);

        // Randomized transactions
        for (int j = 0; j < 8; j++) begin
            rd  = bit'($urandom_range(0, 1));
            a   = 26'($urandom);
            cnt = int'($urandom_range(0, 12));
            request(rd, bit'($urandom_range(0, 1)), a);
            send_token(cnt, rd ? 1 : 9, 1'b1);
            finish_txn(rd, bus.reqInstr, a, cnt, -1, int'($urandom_range(0, 8)) - 1, 8);
        end
        check("no_err_clean", bus.protoErr, 0);

        // Message during injection, then a stray return hit
        a = 26'($urandom);
        request(1'b0, 1'b0, a);
        send_token(0, 9, 1'b1);
        finish_txn(1'b0, 1'b0, a, 0, -1, 2, 8);
        check("msg_no_err", bus.protoErr, 0);
        bus.RDdest = ID;
        tick();
        bus.RDdest = 4'd0;
        check("stray_rd_err", bus.protoErr, 1);
        tick();
        check("err_sticky", bus.protoErr, 1);

        // Reset in the middle of a read return
        a = 26'($urandom);
        request(1'b1, 1'b0, a);
        send_token(0, 1, 1'b1);
        finish_txn(1'b1, 1'b0, a, 0, -1, -1, 3);
        resetB = 1'b0;
        #1;
        check("mid_rst_slot", out_slot(), 40'd0);
        check("mid_rst_ready", bus.reqReady, 1);
        check("mid_rst_misc", {bus.rdValid, bus.rdIndex, bus.rdWord, bus.done, bus.protoErr, bus.wrIndex}, 0);
        #2;
        resetB = 1'b1;
        a = 26'($urandom);
        request(1'b1, 1'b0, a);
        send_token(0, 1, 1'b1);
        finish_txn(1'b1, 1'b0, a, 0, -1, -1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
